mux_nto1_scan: RTL and testbench

//   Parametrised N-to-1 registered multiplexer with a valid/ready output stage
//   and two modes: manual (per-cycle select) and scan (one hardware sweep over
//   an enable mask). Successor to the fixed 8:1 combinational mux. It feeds

---
 rtl/mux_nto1_scan.sv | 237 +++++++++++++++++++++++
 tb/tb_mux_nto1_scan.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_scan.sv
`default_nettype none
// ============================================================================
// Module   : mux_nto1_scan
// Purpose  : Parametrised N-to-1 registered multiplexer with a valid/ready
//            output stage. Manual mode forwards the channel chosen by sel_in
//            on every cycle the output register is free. Scan mode performs
//            one ascending sweep over the enabled channels latched at start,
//            dwelling HOLD_CYC free cycles per channel.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset (released synchronously)
//            data_in    - packed channels, channel i = data_in[i*DATA_W +: DATA_W]
//            mode       - 0 = manual, 1 = scan (acted on together with start)
//            sel_in     - manual-mode channel select
//            ch_en      - scan enable mask, latched on start
//            start      - scan request pulse
//            out_data   - selected sample
//            out_ch     - channel index of out_data
//            out_valid  - out_data/out_ch are valid
//            out_ready  - consumer accepts (transfer = out_valid & out_ready)
//            busy       - high while a sweep is in SCAN or DRAIN
//            done       - one-cycle pulse at the end of a sweep
//            sel_err    - one-cycle pulse when manual sel_in >= NUM_CH
// Revision : 1.0 - initial release
// ============================================================================
module mux_nto1_scan #(
  parameter  int NUM_CH   = 8,
  parameter  int DATA_W   = 8,
  parameter  int HOLD_CYC = 1,
  localparam int SEL_W    = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic                     start,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     sel_err
);

  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [SEL_W:0]   NUM_CH_X   = (SEL_W+1)'(NUM_CH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // --------------------------------------------------------------------------
  // Reset synchroniser: assertion reaches every flop immediately, release is
  // aligned to clk so no flop sees a release near its active edge.
  // --------------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  // --------------------------------------------------------------------------
  // Channel unpacking and selection
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] ch [NUM_CH];

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
      assign ch[g] = data_in[g*DATA_W +: DATA_W];
    end
  endgenerate

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [NUM_CH-1:0] en_q;
  logic [SEL_W-1:0]  ptr;
  logic [CNT_W-1:0]  cnt;

  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] ptr_data;
  logic [SEL_W-1:0]  first_en;
  logic [SEL_W-1:0]  next_ptr;
  logic              has_next;
  logic              sel_ok;
  logic              free;
  logic              dwell_last;

  // Compare-based muxes keep out-of-range selects (non power-of-2 NUM_CH)
  // from indexing past the channel array.
  always_comb begin
    sel_data = '0;
    ptr_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_in == SEL_W'(i)) sel_data = ch[i];
      if (ptr    == SEL_W'(i)) ptr_data = ch[i];
    end
  end

  // Descending walk so the lowest qualifying index is the one that sticks.
  always_comb begin
    first_en = '0;
    next_ptr = '0;
    has_next = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_en[i]) first_en = SEL_W'(i);
      if (en_q[i] && (SEL_W'(i) > ptr)) begin
        next_ptr = SEL_W'(i);
        has_next = 1'b1;
      end
    end
  end

  assign sel_ok     = ({1'b0, sel_in} < NUM_CH_X);
  assign free       = !out_valid || out_ready;
  assign dwell_last = (cnt == DWELL_LAST);
  assign busy       = (state != ST_IDLE);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state <= ST_IDLE;
    else            state <= next_state;
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start && mode && (|ch_en))            next_state = ST_SCAN;
      ST_SCAN:  if (free && dwell_last && !has_next)      next_state = ST_DRAIN;
      ST_DRAIN: if (out_valid && out_ready)               next_state = ST_IDLE;
      default:                                            next_state = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output / datapath next values
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] nxt_data;
  logic [SEL_W-1:0]  nxt_ch;
  logic              nxt_valid;
  logic              nxt_done;
  logic              nxt_err;
  logic [NUM_CH-1:0] nxt_en;
  logic [SEL_W-1:0]  nxt_ptr;
  logic [CNT_W-1:0]  nxt_cnt;

  always_comb begin
    nxt_data  = out_data;
    nxt_ch    = out_ch;
    nxt_valid = out_valid;
    nxt_done  = 1'b0;
    nxt_err   = 1'b0;
    nxt_en    = en_q;
    nxt_ptr   = ptr;
    nxt_cnt   = cnt;
    case (state)
      ST_IDLE: begin
        if (start && mode) begin
          // Start wins over manual selection; a pending sample still
          // completes because SCAN only loads when the register is free.
          nxt_en   = ch_en;
          nxt_ptr  = first_en;
          nxt_cnt  = '0;
          nxt_done = ~(|ch_en);
          if (free) nxt_valid = 1'b0;
        end else if (free) begin
          if (!mode && sel_ok) begin
            nxt_data  = sel_data;
            nxt_ch    = sel_in;
            nxt_valid = 1'b1;
          end else begin
            nxt_valid = 1'b0;
            nxt_err   = !mode;
          end
        end
      end
      ST_SCAN: begin
        // Dwell counter only advances on free edges, so a stall can never
        // skip or repeat a channel.
        if (free) begin
          if (dwell_last) begin
            nxt_data  = ptr_data;
            nxt_ch    = ptr;
            nxt_valid = 1'b1;
            nxt_cnt   = '0;
            if (has_next) nxt_ptr = next_ptr;
          end else begin
            nxt_cnt   = cnt + CNT_W'(1);
            nxt_valid = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        if (out_valid && out_ready) begin
          nxt_valid = 1'b0;
          nxt_done  = 1'b1;
        end
      end
      default: nxt_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      sel_err   <= 1'b0;
      en_q      <= '0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      out_data  <= nxt_data;
      out_ch    <= nxt_ch;
      out_valid <= nxt_valid;
      done      <= nxt_done;
      sel_err   <= nxt_err;
      en_q      <= nxt_en;
      ptr       <= nxt_ptr;
      cnt       <= nxt_cnt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_nto1_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_nto1_scan
// Purpose  : Self-checking bench for mux_nto1_scan. Three instances share the
//            stimulus: 8 channels / dwell 1, 6 channels / dwell 1 and
//            8 channels / dwell 3. Expected samples are queued when a scenario
//            is driven and popped when a transfer is observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_nto1_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] data_in;
  logic        mode;
  logic        start;
  logic        out_ready;
  logic [2:0]  sel_in;
  logic [7:0]  ch_en;

  logic [7:0] out_data,   out_data_6,  out_data_3;
  logic [2:0] out_ch,     out_ch_6,    out_ch_3;
  logic       out_valid,  out_valid_6, out_valid_3;
  logic       busy,       busy_6,      busy_3;
  logic       done,       done_6,      done_3;
  logic       sel_err,    sel_err_6,   sel_err_3;

  int checks   = 0;
  int failures = 0;

  logic [10:0] q  [$];
  logic [10:0] q3 [$];

  always #5 clk = ~clk;

  mux_nto1_scan #(.NUM_CH(8), .DATA_W(8), .HOLD_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .mode(mode), .sel_in(sel_in),
    .ch_en(ch_en), .start(start), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .sel_err(sel_err));

  mux_nto1_scan #(.NUM_CH(6), .DATA_W(8), .HOLD_CYC(1)) dut6 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in[47:0]), .mode(mode), .sel_in(sel_in),
    .ch_en(ch_en[5:0]), .start(start), .out_data(out_data_6), .out_ch(out_ch_6),
    .out_valid(out_valid_6), .out_ready(out_ready), .busy(busy_6), .done(done_6),
    .sel_err(sel_err_6));

  mux_nto1_scan #(.NUM_CH(8), .DATA_W(8), .HOLD_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .mode(mode), .sel_in(sel_in),
    .ch_en(ch_en), .start(start), .out_data(out_data_3), .out_ch(out_ch_3),
    .out_valid(out_valid_3), .out_ready(out_ready), .busy(busy_3), .done(done_3),
    .sel_err(sel_err_3));

  task automatic push_sweep(input logic [7:0] mask, input bit to_q3);
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        q.push_back({8'hA0 + 8'(i), 3'(i)});
        if (to_q3) q3.push_back({8'hA0 + 8'(i), 3'(i)});
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mode = 1'b0; start = 1'b0; out_ready = 1'b1;
    sel_in = 3'd0; ch_en = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_data, out_ch, out_valid, busy, done, sel_err} !== 15'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {out_data, out_ch, out_valid, busy, done, sel_err});
    end
    checks++;
    if ({out_valid_6, out_valid_3, busy_3, done_3} !== 4'h0) begin
      failures++;
      $display("FAIL reset_other_instances got=%b exp=0000", {out_valid_6, out_valid_3, busy_3, done_3});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_manual;
    logic [10:0] e;
    q.delete();
    mode = 1'b0; start = 1'b0; out_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel_in = 3'(s);
      q.push_back({8'hA0 + 8'(s), 3'(s)});
      @(posedge clk); @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
        failures++;
        $display("FAIL manual_valid sel=%0d got=%b exp=1", s, out_valid);
      end
      e = q.pop_front();
      checks++;
      if ({out_data, out_ch} !== e) begin
        failures++;
        $display("FAIL manual_sample sel=%0d got=%h/%0d exp=%h/%0d", s, out_data, out_ch, e[10:3], e[2:0]);
      end
    end
  endtask

  task automatic test_sel_err;
    sel_in = 3'd7;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({out_valid_6, sel_err_6} !== 2'b01) begin
      failures++;
      $display("FAIL sel_err_range got valid/err=%b%b exp=01", out_valid_6, sel_err_6);
    end
    checks++;
    if (sel_err !== 1'b0) begin
      failures++;
      $display("FAIL sel_err_in_range_8ch got=%b exp=0", sel_err);
    end
    sel_in = 3'd5;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({sel_err_6, out_valid_6, out_data_6, out_ch_6} !== {1'b0, 1'b1, 8'hA5, 3'd5}) begin
      failures++;
      $display("FAIL sel_err_recover got=%b/%b/%h/%0d exp=0/1/a5/5", sel_err_6, out_valid_6, out_data_6, out_ch_6);
    end
  endtask

  task automatic test_scan;
    logic [10:0] e;
    int prev, prev3, dn, dn3;
    q.delete(); q3.delete();
    push_sweep(8'hA5, 1'b1);
    mode = 1'b1; ch_en = 8'hA5; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL scan_busy_rise got=%b exp=1", busy);
    end
    prev = -1; prev3 = -1; dn = 0; dn3 = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid && out_ready) begin
        checks++;
        e = (q.size() != 0) ? q.pop_front() : 11'h7FF;
        if ({out_data, out_ch} !== e || (prev >= 0 && c - prev != 1)) begin
          failures++;
          $display("FAIL scan_seq c=%0d got=%h/%0d exp=%h/%0d gap=%0d", c, out_data, out_ch, e[10:3], e[2:0], c - prev);
        end
        prev = c;
      end
      if (out_valid_3 && out_ready) begin
        checks++;
        e = (q3.size() != 0) ? q3.pop_front() : 11'h7FF;
        if ({out_data_3, out_ch_3} !== e || (prev3 >= 0 && c - prev3 != 3)) begin
          failures++;
          $display("FAIL scan_hold3 c=%0d got=%h/%0d exp=%h/%0d gap=%0d", c, out_data_3, out_ch_3, e[10:3], e[2:0], c - prev3);
        end
        prev3 = c;
      end
      if (done)   dn++;
      if (done_3) dn3++;
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (q.size() != 0 || q3.size() != 0) begin
      failures++;
      $display("FAIL scan_missing got left=%0d/%0d exp=0/0", q.size(), q3.size());
    end
    checks++;
    if (dn != 1 || dn3 != 1) begin
      failures++;
      $display("FAIL scan_done_count got=%0d/%0d exp=1/1", dn, dn3);
    end
    checks++;
    if ({busy, busy_3, out_valid} !== 3'b000) begin
      failures++;
      $display("FAIL scan_idle_after got=%b exp=000", {busy, busy_3, out_valid});
    end
  endtask

  task automatic test_backpressure;
    logic [10:0] e;
    int hold, dn;
    q.delete(); q3.delete();
    push_sweep(8'hA5, 1'b1);
    mode = 1'b1; ch_en = 8'hA5; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    hold = 0; dn = 0;
    for (int c = 0; c < 24; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      if (out_valid && out_data == 8'hA2) hold++;
      if (out_valid && out_ready) begin
        checks++;
        e = (q.size() != 0) ? q.pop_front() : 11'h7FF;
        if ({out_data, out_ch} !== e) begin
          failures++;
          $display("FAIL bp_seq c=%0d got=%h/%0d exp=%h/%0d", c, out_data, out_ch, e[10:3], e[2:0]);
        end
      end
      if (out_valid_3 && out_ready) begin
        checks++;
        e = (q3.size() != 0) ? q3.pop_front() : 11'h7FF;
        if ({out_data_3, out_ch_3} !== e) begin
          failures++;
          $display("FAIL bp_seq_hold3 c=%0d got=%h/%0d exp=%h/%0d", c, out_data_3, out_ch_3, e[10:3], e[2:0]);
        end
      end
      if (done) dn++;
      @(posedge clk); @(negedge clk);
    end
    out_ready = 1'b1;
    checks++;
    if (hold != 4) begin
      failures++;
      $display("FAIL bp_hold_a2 got=%0d exp=4", hold);
    end
    checks++;
    if (q.size() != 0 || q3.size() != 0 || dn != 1) begin
      failures++;
      $display("FAIL bp_complete got left=%0d/%0d done=%0d exp=0/0/1", q.size(), q3.size(), dn);
    end
  endtask

  task automatic test_empty_mask;
    int dn, vn, bn;
    mode = 1'b1; ch_en = 8'h00; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL empty_done_pulse got=%b exp=1", done);
    end
    dn = 0; vn = 0; bn = 0;
    for (int c = 0; c < 5; c++) begin
      if (done) dn++;
      if (out_valid) vn++;
      if (busy) bn++;
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (dn != 1 || vn != 0 || bn != 0) begin
      failures++;
      $display("FAIL empty_mask got done=%0d valid=%0d busy=%0d exp=1/0/0", dn, vn, bn);
    end
  endtask

  task automatic test_reset_mid_scan;
    logic [10:0] e;
    int dn;
    bit seen;
    mode = 1'b1; ch_en = 8'hA5; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (out_valid && out_ch == 3'd2) seen = 1;
      else begin @(posedge clk); @(negedge clk); end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL midscan_reach_ch2 got=%b exp=1", seen);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_data, out_ch, out_valid, busy, done, sel_err} !== 15'h0) begin
      failures++;
      $display("FAIL midscan_async_reset got=%h exp=0", {out_data, out_ch, out_valid, busy, done, sel_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    q.delete();
    push_sweep(8'hA5, 1'b0);
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid && out_ready) begin
        checks++;
        e = (q.size() != 0) ? q.pop_front() : 11'h7FF;
        if ({out_data, out_ch} !== e) begin
          failures++;
          $display("FAIL midscan_resweep c=%0d got=%h/%0d exp=%h/%0d", c, out_data, out_ch, e[10:3], e[2:0]);
        end
      end
      if (done) dn++;
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (q.size() != 0 || dn != 1) begin
      failures++;
      $display("FAIL midscan_resweep_end got left=%0d done=%0d exp=0/1", q.size(), dn);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) data_in[i*8 +: 8] = 8'hA0 + 8'(i);
    test_reset();
    test_manual();
    test_sel_err();
    test_scan();
    test_backpressure();
    test_empty_mask();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
